// File: rtl/morra_scheduler_if.sv
// Player move handshakes and game-engine move/result bus for morra_scheduler.
// slave: scheduler side; master: players plus engine side.
interface morra_scheduler_if;
  localparam int unsigned MOVE_W = 2;

  logic              p1_valid;
  logic [MOVE_W-1:0] p1_move;
  logic              p1_ready;
  logic              p2_valid;
  logic [MOVE_W-1:0] p2_move;
  logic              p2_ready;
  logic [MOVE_W-1:0] mc_primo;
  logic [MOVE_W-1:0] mc_secondo;
  logic              mc_inizio;
  logic [1:0]        mc_manche;
  logic [1:0]        mc_partita;

  modport slave (
    input  p1_valid, p1_move, p2_valid, p2_move, mc_manche, mc_partita,
    output p1_ready, p2_ready, mc_primo, mc_secondo, mc_inizio
  );

  modport master (
    output p1_valid, p1_move, p2_valid, p2_move, mc_manche, mc_partita,
    input  p1_ready, p2_ready, mc_primo, mc_secondo, mc_inizio
  );
endinterface

// File: rtl/morra_scheduler.sv
// Morra match scheduler: collects both players' moves, issues them to the engine,
// captures and reports the result and keeps score. Optional COLLECT timeout: MORRA_SCHED_TIMEOUT_EN.
module morra_scheduler (
  input  logic                clk,
  input  logic                rst_n,
  morra_scheduler_if.slave    bus,
  input  logic                new_game_i,
  output logic                result_valid_o,
  output logic [1:0]          result_manche_o,
  output logic [1:0]          result_partita_o,
  output logic [3:0]          wins1_o,
  output logic [3:0]          wins2_o,
  output logic [4:0]          rounds_o,
  output logic                busy_o,
  output logic                game_over_o,
  output logic                timeout_o
);

  localparam int unsigned MOVE_W  = 2;
  localparam int unsigned WINS_W  = 4;
  localparam int unsigned RND_W   = 5;
  localparam int unsigned TO_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_REPORT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [MOVE_W-1:0]   mv1_q, mv1_d, mv2_q, mv2_d;
  logic                lat1_q, lat1_d, lat2_q, lat2_d;
  logic                first_q, first_d;
  logic [WINS_W-1:0]   wins1_q, wins1_d, wins2_q, wins2_d;
  logic [RND_W-1:0]    rounds_q, rounds_d;
  logic [1:0]          res_manche_q, res_manche_d, res_partita_q, res_partita_d;
  logic                res_valid_q, res_valid_d;
  logic                p1_ready_q, p1_ready_d, p2_ready_q, p2_ready_d;
  logic [MOVE_W-1:0]   mc_primo_q, mc_primo_d, mc_secondo_q, mc_secondo_d;
  logic                mc_inizio_q, mc_inizio_d;
  logic                busy_q, busy_d, game_over_q, game_over_d;
  logic                hs1, hs2;
`ifdef MORRA_SCHED_TIMEOUT_EN
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mv1_q         <= '0;
      mv2_q         <= '0;
      lat1_q        <= 1'b0;
      lat2_q        <= 1'b0;
      first_q       <= 1'b0;
      wins1_q       <= '0;
      wins2_q       <= '0;
      rounds_q      <= '0;
      res_manche_q  <= '0;
      res_partita_q <= '0;
      res_valid_q   <= 1'b0;
      p1_ready_q    <= 1'b0;
      p2_ready_q    <= 1'b0;
      mc_primo_q    <= '0;
      mc_secondo_q  <= '0;
      mc_inizio_q   <= 1'b0;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
`ifdef MORRA_SCHED_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mv1_q         <= mv1_d;
      mv2_q         <= mv2_d;
      lat1_q        <= lat1_d;
      lat2_q        <= lat2_d;
      first_q       <= first_d;
      wins1_q       <= wins1_d;
      wins2_q       <= wins2_d;
      rounds_q      <= rounds_d;
      res_manche_q  <= res_manche_d;
      res_partita_q <= res_partita_d;
      res_valid_q   <= res_valid_d;
      p1_ready_q    <= p1_ready_d;
      p2_ready_q    <= p2_ready_d;
      mc_primo_q    <= mc_primo_d;
      mc_secondo_q  <= mc_secondo_d;
      mc_inizio_q   <= mc_inizio_d;
      busy_q        <= busy_d;
      game_over_q   <= game_over_d;
`ifdef MORRA_SCHED_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  // READY registers are only ever high in COLLECT, so they qualify the handshake directly
  assign hs1 = p1_ready_q & bus.p1_valid;
  assign hs2 = p2_ready_q & bus.p2_valid;

  // Next state, datapath and next values of every registered output
  always_comb begin
    state_d       = state_q;
    mv1_d         = mv1_q;
    mv2_d         = mv2_q;
    lat1_d        = lat1_q;
    lat2_d        = lat2_q;
    first_d       = first_q;
    wins1_d       = wins1_q;
    wins2_d       = wins2_q;
    rounds_d      = rounds_q;
    res_manche_d  = res_manche_q;
    res_partita_d = res_partita_q;
    res_valid_d   = 1'b0;
`ifdef MORRA_SCHED_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (new_game_i) begin
          state_d  = S_COLLECT;
          mv1_d    = '0;
          mv2_d    = '0;
          lat1_d   = 1'b0;
          lat2_d   = 1'b0;
          wins1_d  = '0;
          wins2_d  = '0;
          rounds_d = '0;
          first_d  = 1'b1;
`ifdef MORRA_SCHED_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (new_game_i) begin
          mv1_d    = '0;
          mv2_d    = '0;
          lat1_d   = 1'b0;
          lat2_d   = 1'b0;
          wins1_d  = '0;
          wins2_d  = '0;
          rounds_d = '0;
          first_d  = 1'b1;
`ifdef MORRA_SCHED_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          if (hs1) begin
            mv1_d  = bus.p1_move;
            lat1_d = 1'b1;
          end
          if (hs2) begin
            mv2_d  = bus.p2_move;
            lat2_d = 1'b1;
          end
`ifdef MORRA_SCHED_TIMEOUT_EN
          to_cnt_d = TO_W'(to_cnt_q + TO_W'(1));
`endif
          if (lat1_d && lat2_d) begin
            state_d = S_ISSUE;
`ifdef MORRA_SCHED_TIMEOUT_EN
          end else if (to_cnt_d == {TO_W{1'b1}}) begin
            // Give up on the missing player(s): their move goes out as 00
            state_d   = S_ISSUE;
            timeout_d = 1'b1;
            if (!lat1_d) mv1_d = '0;
            if (!lat2_d) mv2_d = '0;
`endif
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        first_d = 1'b0;
      end
      S_WAIT: begin
        state_d       = S_REPORT;
        res_manche_d  = bus.mc_manche;
        res_partita_d = bus.mc_partita;
        res_valid_d   = 1'b1;
        if (bus.mc_manche == 2'b01 && wins1_q != {WINS_W{1'b1}})
          wins1_d = WINS_W'(wins1_q + WINS_W'(1));
        if (bus.mc_manche == 2'b10 && wins2_q != {WINS_W{1'b1}})
          wins2_d = WINS_W'(wins2_q + WINS_W'(1));
        if (bus.mc_manche != 2'b00 && rounds_q != {RND_W{1'b1}})
          rounds_d = RND_W'(rounds_q + RND_W'(1));
      end
      S_REPORT: begin
        if (res_partita_q != 2'b00) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
          mv1_d   = '0;
          mv2_d   = '0;
          lat1_d  = 1'b0;
          lat2_d  = 1'b0;
`ifdef MORRA_SCHED_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    p1_ready_d   = (state_d == S_COLLECT) && !lat1_d;
    p2_ready_d   = (state_d == S_COLLECT) && !lat2_d;
    mc_primo_d   = (state_d == S_ISSUE) ? mv1_d : '0;
    mc_secondo_d = (state_d == S_ISSUE) ? mv2_d : '0;
    mc_inizio_d  = (state_d == S_ISSUE) && first_d;
    busy_d       = (state_d == S_COLLECT) || (state_d == S_ISSUE) ||
                   (state_d == S_WAIT)    || (state_d == S_REPORT);
    game_over_d  = (state_d == S_DONE);
  end

  assign bus.p1_ready     = p1_ready_q;
  assign bus.p2_ready     = p2_ready_q;
  assign bus.mc_primo     = mc_primo_q;
  assign bus.mc_secondo   = mc_secondo_q;
  assign bus.mc_inizio    = mc_inizio_q;
  assign result_valid_o   = res_valid_q;
  assign result_manche_o  = res_manche_q;
  assign result_partita_o = res_partita_q;
  assign wins1_o          = wins1_q;
  assign wins2_o          = wins2_q;
  assign rounds_o         = rounds_q;
  assign busy_o           = busy_q;
  assign game_over_o      = game_over_q;
`ifdef MORRA_SCHED_TIMEOUT_EN
  assign timeout_o        = timeout_q;
`else
  assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_morra_scheduler.sv
// Self-checking bench for morra_scheduler: directed scenarios plus randomized manches
// checked against a score-keeping reference model.
module tb_morra_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       result_valid, busy, game_over, timeout;
  logic [1:0] result_manche, result_partita;
  logic [3:0] wins1, wins2;
  logic [4:0] rounds;

  int errors = 0;
  int checks = 0;

  // Reference score model
  int m_w1, m_w2, m_rounds;
  logic m_first;

  morra_scheduler_if bus_if ();

  morra_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus_if),
    .new_game_i       (new_game),
    .result_valid_o   (result_valid),
    .result_manche_o  (result_manche),
    .result_partita_o (result_partita),
    .wins1_o          (wins1),
    .wins2_o          (wins2),
    .rounds_o         (rounds),
    .busy_o           (busy),
    .game_over_o      (game_over),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  logic [31:0] all_outs;
  assign all_outs = {busy, game_over, timeout, result_valid, result_manche, result_partita,
                     wins1, wins2, rounds, bus_if.p1_ready, bus_if.p2_ready,
                     bus_if.mc_primo, bus_if.mc_secondo, bus_if.mc_inizio};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Plays one manche from COLLECT with no latched move; returns what was observed.
  task automatic play_round(
    input  logic [1:0]  m1, input int d1, input logic [1:0] m2, input int d2,
    input  logic [1:0]  man, input logic [1:0] par,
    output logic [1:0]  primo, output logic [1:0] secondo, output logic inizio,
    output logic [3:0]  after_issue, output logic rv_wait, output logic rv,
    output logic [1:0]  rman, output logic [1:0] rpar,
    output logic [31:0] hist1, output logic done_ok);
    logic sent1, sent2, r1, r2;
    sent1 = 1'b0; sent2 = 1'b0; hist1 = '0;
    for (int c = 0; c < 100 && !(sent1 && sent2); c++) begin
      r1 = bus_if.p1_ready;
      r2 = bus_if.p2_ready;
      if (c < 32) hist1[c] = r1;
      bus_if.p1_valid = !sent1 && (c >= d1);
      bus_if.p1_move  = m1;
      bus_if.p2_valid = !sent2 && (c >= d2);
      bus_if.p2_move  = m2;
      tick();
      if (bus_if.p1_valid && r1) sent1 = 1'b1;
      if (bus_if.p2_valid && r2) sent2 = 1'b1;
    end
    done_ok = sent1 && sent2;
    bus_if.p1_valid = 1'b0;
    bus_if.p2_valid = 1'b0;
    primo   = bus_if.mc_primo;
    secondo = bus_if.mc_secondo;
    inizio  = bus_if.mc_inizio;
    bus_if.mc_manche  = man;
    bus_if.mc_partita = par;
    tick();
    after_issue = {bus_if.mc_primo, bus_if.mc_secondo};
    rv_wait = result_valid;
    tick();
    rv = result_valid; rman = result_manche; rpar = result_partita;
    bus_if.mc_manche  = 2'b00;
    bus_if.mc_partita = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (all_outs !== 32'h0) begin errors++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
    #20 rst_n = 1'b1;
    tick(); tick();
    checks++; if ({busy, game_over, bus_if.p1_ready} !== 3'b000) begin errors++; $display("FAIL idle_flags got=%b exp=000", {busy, game_over, bus_if.p1_ready}); end
  endtask

  task automatic test_first_manche();
    logic [1:0] pr, se, rm, rp; logic iz, rvw, rv, ok; logic [3:0] ai; logic [31:0] h;
    pulse_new_game();
    checks++; if ({busy, bus_if.p1_ready, bus_if.p2_ready} !== 3'b111) begin errors++; $display("FAIL collect_entry got=%b exp=111", {busy, bus_if.p1_ready, bus_if.p2_ready}); end
    play_round(2'b10, 0, 2'b10, 0, 2'b11, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_handshake got=0 exp=1"); end
    checks++; if ({iz, pr, se} !== 5'b1_10_10) begin errors++; $display("FAIL first_issue got=%b exp=11010", {iz, pr, se}); end
    checks++; if ({rvw, rv, rm} !== 4'b0_1_11) begin errors++; $display("FAIL first_report got=%b exp=0111", {rvw, rv, rm}); end
    checks++; if ({wins1, wins2, rounds} !== {4'd0, 4'd0, 5'd1}) begin errors++; $display("FAIL first_score got=%0d/%0d/%0d exp=0/0/1", wins1, wins2, rounds); end
  endtask

  task automatic test_second_manche();
    logic [1:0] pr, se, rm, rp; logic iz, rvw, rv, ok; logic [3:0] ai; logic [31:0] h;
    play_round(2'b01, 0, 2'b11, 5, 2'b01, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if (h[5:1] !== 5'b0 || h[0] !== 1'b1) begin errors++; $display("FAIL p1_ready_hold got=%b exp=000001", h[5:0]); end
    checks++; if ({iz, pr, se} !== 5'b0_01_11) begin errors++; $display("FAIL second_issue got=%b exp=00111", {iz, pr, se}); end
    checks++; if (ai !== 4'b0) begin errors++; $display("FAIL single_issue got=%b exp=0000", ai); end
    checks++; if ({wins1, wins2, rounds} !== {4'd1, 4'd0, 5'd2}) begin errors++; $display("FAIL second_score got=%0d/%0d/%0d exp=1/0/2", wins1, wins2, rounds); end
    checks++; if (result_manche !== 2'b01) begin errors++; $display("FAIL result_hold got=%b exp=01", result_manche); end
  endtask

  task automatic test_random_manches();
    logic [1:0] pr, se, rm, rp, m1, m2, man; logic iz, rvw, rv, ok; logic [3:0] ai; logic [31:0] h;
    int d1, d2;
    m_w1 = 1; m_w2 = 0; m_rounds = 2; m_first = 1'b0;
    for (int r = 0; r < 12; r++) begin
      m1 = 2'($urandom_range(3)); m2 = 2'($urandom_range(3)); man = 2'($urandom_range(3));
      d1 = $urandom_range(4); d2 = $urandom_range(4);
      play_round(m1, d1, m2, d2, man, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
      if (man == 2'b01) m_w1 = (m_w1 < 15) ? m_w1 + 1 : 15;
      if (man == 2'b10) m_w2 = (m_w2 < 15) ? m_w2 + 1 : 15;
      if (man != 2'b00) m_rounds = (m_rounds < 31) ? m_rounds + 1 : 31;
      checks++; if ({ok, pr, se, iz} !== {1'b1, m1, m2, m_first}) begin errors++; $display("FAIL rnd%0d_issue got=%b exp=%b", r, {ok, pr, se, iz}, {1'b1, m1, m2, m_first}); end
      checks++; if ({rvw, rv, rm, rp} !== {2'b01, man, 2'b00}) begin errors++; $display("FAIL rnd%0d_result got=%b exp=%b", r, {rvw, rv, rm, rp}, {2'b01, man, 2'b00}); end
      checks++; if (wins1 !== 4'(m_w1) || wins2 !== 4'(m_w2) || rounds !== 5'(m_rounds)) begin errors++; $display("FAIL rnd%0d_score got=%0d/%0d/%0d exp=%0d/%0d/%0d", r, wins1, wins2, rounds, m_w1, m_w2, m_rounds); end
    end
  endtask

  task automatic test_game_over();
    logic [1:0] pr, se, rm, rp; logic iz, rvw, rv, ok; logic [3:0] ai; logic [31:0] h;
    play_round(2'b11, 1, 2'b01, 0, 2'b01, 2'b01, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if ({rv, rp} !== 3'b1_01) begin errors++; $display("FAIL final_report got=%b exp=101", {rv, rp}); end
    tick(); tick();
    checks++; if ({game_over, busy, bus_if.p1_ready, bus_if.p2_ready} !== 4'b1000) begin errors++; $display("FAIL done_flags got=%b exp=1000", {game_over, busy, bus_if.p1_ready, bus_if.p2_ready}); end
    pulse_new_game();
    checks++; if ({wins1, wins2, rounds, game_over} !== 14'b0) begin errors++; $display("FAIL new_game_clear got=%h exp=0", {wins1, wins2, rounds, game_over}); end
    play_round(2'b01, 0, 2'b10, 2, 2'b10, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if ({ok, iz, pr, se} !== 6'b1_1_01_10) begin errors++; $display("FAIL restart_issue got=%b exp=110110", {ok, iz, pr, se}); end
  endtask

  task automatic test_invalid_and_saturation();
    logic [1:0] pr, se, rm, rp; logic iz, rvw, rv, ok; logic [3:0] ai; logic [31:0] h;
    bus_if.p1_valid = 1'b1; bus_if.p1_move = 2'b11;
    tick();
    bus_if.p1_valid = 1'b0;
    checks++; if (bus_if.p1_ready !== 1'b0) begin errors++; $display("FAIL latched_ready got=%b exp=0", bus_if.p1_ready); end
    pulse_new_game();
    checks++; if ({bus_if.p1_ready, wins2, rounds} !== 10'b1_0000_00000) begin errors++; $display("FAIL collect_new_game got=%b exp=1000000000", {bus_if.p1_ready, wins2, rounds}); end
    play_round(2'b10, 0, 2'b01, 1, 2'b00, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if ({ok, iz, rv, rm, wins1, wins2, rounds} !== {3'b111, 2'b00, 13'b0}) begin errors++; $display("FAIL invalid_manche got=%b", {ok, iz, rv, rm, wins1, wins2, rounds}); end
    for (int r = 0; r < 16; r++)
      play_round(2'b01, 0, 2'b10, 0, 2'b10, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if ({wins1, wins2, rounds} !== {4'd0, 4'd15, 5'd16}) begin errors++; $display("FAIL wins2_sat got=%0d/%0d/%0d exp=0/15/16", wins1, wins2, rounds); end
    for (int r = 0; r < 17; r++)
      play_round(2'b01, 0, 2'b10, 0, 2'b10, 2'b00, pr, se, iz, ai, rvw, rv, rm, rp, h, ok);
    checks++; if ({wins2, rounds} !== {4'd15, 5'd31}) begin errors++; $display("FAIL rounds_sat got=%0d/%0d exp=15/31", wins2, rounds); end
  endtask

  task automatic test_reset_mid_wait();
    logic saw_rv;
    bus_if.p1_valid = 1'b1; bus_if.p1_move = 2'b10;
    bus_if.p2_valid = 1'b1; bus_if.p2_move = 2'b01;
    bus_if.mc_manche = 2'b01;
    tick();
    bus_if.p1_valid = 1'b0; bus_if.p2_valid = 1'b0;
    checks++; if (bus_if.mc_primo !== 2'b10) begin errors++; $display("FAIL pre_reset_issue got=%b exp=10", bus_if.mc_primo); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (all_outs !== 32'h0) begin errors++; $display("FAIL async_reset got=%h exp=0", all_outs); end
    #2 rst_n = 1'b1;
    saw_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (result_valid || busy) saw_rv = 1'b1;
    end
    bus_if.mc_manche = 2'b00;
    checks++; if ({saw_rv, all_outs} !== 33'h0) begin errors++; $display("FAIL post_reset_idle got=%b/%h exp=0/0", saw_rv, all_outs); end
  endtask

  task automatic test_timeout();
    logic seen, issued; logic [1:0] pr, se; logic iz; int n;
    pulse_new_game();
    bus_if.p1_valid = 1'b1; bus_if.p1_move = 2'b11;
    seen = 1'b0; issued = 1'b0; n = 0; pr = '0; se = '0; iz = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      bus_if.p1_valid = 1'b0;
      n++;
      if (bus_if.mc_inizio) issued = 1'b1;
      if (timeout) begin
        seen = 1'b1; pr = bus_if.mc_primo; se = bus_if.mc_secondo; iz = bus_if.mc_inizio;
        break;
      end
    end
`ifdef MORRA_SCHED_TIMEOUT_EN
    checks++; if (!seen || n != 63) begin errors++; $display("FAIL timeout_cycle got=%0d/%0d exp=1/63", seen, n); end
    checks++; if ({iz, pr, se} !== 5'b1_11_00) begin errors++; $display("FAIL timeout_issue got=%b exp=11100", {iz, pr, se}); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got=%b exp=0", timeout); end
`else
    checks++; if ({seen, issued} !== 2'b00) begin errors++; $display("FAIL no_timeout got=%b exp=00", {seen, issued}); end
    checks++; if ({busy, bus_if.p1_ready, bus_if.p2_ready} !== 3'b101) begin errors++; $display("FAIL still_collect got=%b exp=101", {busy, bus_if.p1_ready, bus_if.p2_ready}); end
`endif
  endtask

  initial begin
    bus_if.p1_valid = 1'b0; bus_if.p1_move = 2'b00;
    bus_if.p2_valid = 1'b0; bus_if.p2_move = 2'b00;
    bus_if.mc_manche = 2'b00; bus_if.mc_partita = 2'b00;
    test_reset();
    test_first_manche();
    test_second_manche();
    test_random_manches();
    test_game_over();
    test_invalid_and_saturation();
    test_reset_mid_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morra_scheduler.md
MORRA_SCHEDULER -- requirements
Module: morra_scheduler

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 P1_VALID / P1_MOVE / P1_READY  in/in/out  1/2/1  player-1 move handshake; transfer when VALID and READY both high at a rising edge.
REQ-004 P2_VALID / P2_MOVE / P2_READY  in/in/out  1/2/1  player-2 move handshake; same rule.
REQ-005 NEW_GAME  input  1  request to start a new match.
REQ-006 MC_PRIMO, MC_SECONDO  output  2 each  moves driven to the game engine.
REQ-007 MC_INIZIO  output  1  engine start-of-match flag.
REQ-008 MC_MANCHE, MC_PARTITA  input  2 each  engine registered outputs: MANCHE 00 invalid, 01 P1, 10 P2, 11 draw; PARTITA 00 running, else final.
REQ-009 RESULT_VALID / RESULT_MANCHE / RESULT_PARTITA  output  1/2/2  one-cycle report of the captured engine result.
REQ-010 WINS1, WINS2  output  4 each  manche wins per player in the current match.
REQ-011 ROUNDS  output  5  valid (non-00) manches played in the current match.
REQ-012 BUSY, GAME_OVER, TIMEOUT  output  1 each  state flags.

Function
REQ-013 The block SHALL be an FSM with states IDLE, COLLECT, ISSUE, WAIT, REPORT, DONE.
REQ-014 IDLE/DONE: NEW_GAME=1 SHALL clear WINS1, WINS2, ROUNDS and the move latches, set the first flag, and go to COLLECT.
REQ-015 COLLECT: Px_READY SHALL be 1 only while player x's move is not latched; each move is latched on its handshake; both players may transfer in the same cycle.
REQ-016 COLLECT: when both moves are latched (including same-cycle transfer), the next state SHALL be ISSUE.
REQ-017 NEW_GAME in COLLECT SHALL discard latched moves, clear counters, set the first flag and remain in COLLECT; NEW_GAME in ISSUE/WAIT/REPORT SHALL be ignored.
REQ-018 ISSUE (exactly 1 cycle): MC_PRIMO/MC_SECONDO SHALL equal the latched moves; MC_INIZIO SHALL equal the first flag; the first flag clears on exit.
REQ-019 Outside ISSUE, MC_PRIMO=MC_SECONDO=00 and MC_INIZIO=0.
REQ-020 WAIT (1 cycle): MC_MANCHE/MC_PARTITA SHALL be captured at the end of the cycle; ISSUE-to-capture latency is therefore 2 edges.
REQ-021 REPORT (1 cycle): RESULT_VALID=1 with the captured values; RESULT_* hold their values until the next capture.
REQ-022 On entering REPORT: MANCHE 01 increments WINS1, 10 increments WINS2, 11 increments neither; any non-00 value increments ROUNDS; 00 changes no counter.
REQ-023 WINS1/WINS2 SHALL saturate at 15 and ROUNDS at 31.
REQ-024 REPORT exit: PARTITA≠00 goes to DONE, otherwise to COLLECT with move latches cleared.
REQ-025 BUSY=1 in COLLECT/ISSUE/WAIT/REPORT; GAME_OVER=1 only in DONE.

Reset
REQ-026 rst_n low SHALL immediately force IDLE; all outputs 0; counters, latches, RESULT_* and the first flag cleared, including mid-handshake or mid-ISSUE.
REQ-027 The first rising edge after rst_n deasserts SHALL perform normal IDLE evaluation.

Configuration
REQ-028 With MORRA_SCHED_TIMEOUT_EN defined, a 6-bit counter SHALL clear on COLLECT entry and increment each COLLECT cycle; at count 63 any unlatched move is replaced by 00, TIMEOUT pulses 1 cycle, and the FSM goes to ISSUE.
REQ-029 Without MORRA_SCHED_TIMEOUT_EN, COLLECT SHALL wait indefinitely; TIMEOUT is tied to 0.

Verification
REQ-030 Reset, NEW_GAME, P1=10 and P2=10 transferred in the same cycle -> ISSUE on the next cycle with MC_INIZIO=1, MC_PRIMO=10, MC_SECONDO=10; model returns MANCHE=11 -> RESULT_VALID 2 cycles later, WINS1=WINS2=0, ROUNDS=1.
REQ-031 Second manche: P1 at cycle 0, P2 at cycle 5 -> P1_READY=0 on cycles 1-5; single ISSUE with MC_INIZIO=0; model MANCHE=01 -> WINS1=1.
REQ-032 Model MANCHE=01, PARTITA=01 -> DONE, GAME_OVER=1, READYs 0; NEW_GAME -> counters 0, next ISSUE has MC_INIZIO=1.
REQ-033 MANCHE=00 returned -> RESULT_VALID=1 with 00, ROUNDS and WINS unchanged; 16 consecutive P2 wins -> WINS2 stuck at 15.
REQ-034 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, IDLE after release, no RESULT_VALID.
REQ-035 Macro defined, only P1 supplies -> TIMEOUT pulse 63 cycles after COLLECT entry, ISSUE with MC_SECONDO=00; macro undefined -> no ISSUE after 200 cycles.
